// File: rtl/nonce_sweep_sched.sv
// nonce_sweep_sched: hands consecutive nonces to a pool of hash cores,
// collects each core's final h0, counts hits below a target and keeps the
// smallest h0 seen together with the nonce that produced it.
module nonce_sweep_sched #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            nonce_base,
    input  logic [CNT_W-1:0]       nonce_count,
    input  logic [31:0]            target,
    output logic                   busy,
    output logic                   done,
    output logic                   best_valid,
    output logic [31:0]            best_nonce,
    output logic [31:0]            best_h0,
    output logic [CNT_W-1:0]       hit_count,
    output logic [NUM_CORES-1:0]   core_start,
    output logic [31:0]            core_nonce,
    input  logic [NUM_CORES-1:0]   core_done,
    input  logic [32*NUM_CORES-1:0] core_h0
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    state_t               state;
    logic [31:0]          base_r;
    logic [CNT_W-1:0]     count_r;
    logic [31:0]          target_r;
    logic [CNT_W-1:0]     issued;
    logic                 aborted;
    logic [NUM_CORES-1:0] core_busy;
    logic [31:0]          flight_nonce [NUM_CORES];

    logic [NUM_CORES-1:0] accepted;
    logic [NUM_CORES-1:0] busy_after_done;
    logic [NUM_CORES-1:0] launch_onehot;
    logic                 launching;
    logic [31:0]          launch_nonce;
    logic [CNT_W-1:0]     issued_next;

    logic [3:0]           hit_sum;
    logic [31:0]          h0_i;
    logic                 cand_valid;
    logic [31:0]          cand_h0;
    logic [31:0]          cand_nonce;
    logic [CNT_W+3:0]     hit_total;
    logic [CNT_W-1:0]     hit_sat;

    // A done pulse only counts for a core we believe is busy; stray pulses are dropped.
    assign accepted        = core_done & core_busy;
    assign busy_after_done = core_busy & ~accepted;
    assign launch_nonce    = base_r + 32'(issued);
    assign issued_next     = issued + 1'b1;
    assign launching       = (state == ISSUE) && !abort && (launch_onehot != '0);

    // Pick the lowest-index core that is idle in the registered vector, so a core
    // freed this cycle is only reused from the next cycle on.
    always_comb begin
        launch_onehot = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!core_busy[i]) begin
                launch_onehot    = '0;
                launch_onehot[i] = 1'b1;
            end
        end
    end

    // Merge every result arriving this cycle: count hits and walk cores in index
    // order with a strict compare, so ties keep the older best or the lower core.
    always_comb begin
        hit_sum    = '0;
        h0_i       = '0;
        cand_valid = best_valid;
        cand_h0    = best_h0;
        cand_nonce = best_nonce;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (accepted[i]) begin
                h0_i = core_h0[32*i +: 32];
                if (h0_i < target_r) begin
                    hit_sum = hit_sum + 4'd1;
                end
                if (!cand_valid || (h0_i < cand_h0)) begin
                    cand_valid = 1'b1;
                    cand_h0    = h0_i;
                    cand_nonce = flight_nonce[i];
                end
            end
        end
    end

    // Hit counter adds the whole cycle's hits at once and sticks at all-ones.
    assign hit_total = {4'b0000, hit_count} + {{CNT_W{1'b0}}, hit_sum};
    assign hit_sat   = (hit_total[CNT_W+3:CNT_W] != 4'b0000) ? {CNT_W{1'b1}}
                                                             : hit_total[CNT_W-1:0];

    // Sweep controller: state, core tracking, result registers and launch pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_r     <= '0;
            count_r    <= '0;
            target_r   <= '0;
            issued     <= '0;
            aborted    <= 1'b0;
            core_busy  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            best_valid <= 1'b0;
            best_nonce <= '0;
            best_h0    <= '0;
            hit_count  <= '0;
            core_start <= '0;
            core_nonce <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                flight_nonce[i] <= '0;
            end
        end else begin
            core_start <= '0;
            done       <= 1'b0;

            if (!aborted && (accepted != '0)) begin
                hit_count  <= hit_sat;
                best_valid <= cand_valid;
                best_h0    <= cand_h0;
                best_nonce <= cand_nonce;
            end

            core_busy <= busy_after_done | (launching ? launch_onehot : '0);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (launching && launch_onehot[i]) begin
                    flight_nonce[i] <= launch_nonce;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_r     <= nonce_base;
                        count_r    <= nonce_count;
                        target_r   <= target;
                        issued     <= '0;
                        aborted    <= 1'b0;
                        best_valid <= 1'b0;
                        best_h0    <= '0;
                        best_nonce <= '0;
                        hit_count  <= '0;
                        busy       <= 1'b1;
                        state      <= (nonce_count != '0) ? ISSUE : FINISH;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DRAIN;
                    end else if (launching) begin
                        core_start <= launch_onehot;
                        core_nonce <= launch_nonce;
                        issued     <= issued_next;
                        if (issued_next == count_r) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (busy_after_done == '0) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sweep_sched.sv
// tb_nonce_sweep_sched: directed sweeps against a small behavioural model of
// the hash cores (fixed per-core latency, h0 derived from the nonce).
module tb_nonce_sweep_sched;

    localparam int NC = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [31:0]       nonce_base;
    logic [CW-1:0]     nonce_count;
    logic [31:0]       target;
    logic              busy;
    logic              done;
    logic              best_valid;
    logic [31:0]       best_nonce;
    logic [31:0]       best_h0;
    logic [CW-1:0]     hit_count;
    logic [NC-1:0]     core_start;
    logic [31:0]       core_nonce;
    logic [NC-1:0]     core_done = '0;
    logic [32*NC-1:0]  core_h0 = '0;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;

    int            timer [NC] = '{default: 0};
    int            lat [NC]   = '{default: 10};
    logic [31:0]   job_nonce [NC] = '{default: 32'h0};
    int            h0_mode = 0;
    int            launch_core [$];
    logic [31:0]   launch_nonce [$];
    int            launch_cyc [$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_core_done_cyc = 0;
    int            onehot_err = 0;
    int            max_hit_step = 0;
    logic [CW-1:0] prev_hit = '0;
    int            s;

    nonce_sweep_sched #(.NUM_CORES(NC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .nonce_base(nonce_base), .nonce_count(nonce_count), .target(target),
        .busy(busy), .done(done), .best_valid(best_valid), .best_nonce(best_nonce),
        .best_h0(best_h0), .hit_count(hit_count), .core_start(core_start),
        .core_nonce(core_nonce), .core_done(core_done), .core_h0(core_h0)
    );

    always #5 clk = ~clk;

    // Cycle index; everything else samples on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] modelH0(input int core, input logic [31:0] n);
        if (h0_mode == 0) return 32'hFFFF0000 - n;
        return (core == 0) ? 32'h0000_0100 : 32'h0000_0005;
    endfunction

    // Observe the DUT outputs and run the core model once per cycle.
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (core_start != '0) begin
            if ($countones(core_start) != 1) onehot_err = onehot_err + 1;
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    launch_core.push_back(i);
                    launch_nonce.push_back(core_nonce);
                    launch_cyc.push_back(cyc);
                end
            end
        end
        if (hit_count > prev_hit && int'(hit_count - prev_hit) > max_hit_step)
            max_hit_step = int'(hit_count - prev_hit);
        prev_hit = hit_count;

        core_done = '0;
        for (int i = 0; i < NC; i++) begin
            if (reset) begin
                timer[i] = 0;
            end else if (timer[i] > 0) begin
                timer[i] = timer[i] - 1;
                if (timer[i] == 0) begin
                    core_done[i] = 1'b1;
                    core_h0[32*i +: 32] = modelH0(i, job_nonce[i]);
                    last_core_done_cyc = cyc;
                end
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (!reset && core_start[i]) begin
                timer[i]     = lat[i];
                job_nonce[i] = core_nonce;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assert_cnt = assert_cnt + 1;
        if (actual !== expected) begin
            fail_cnt = fail_cnt + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [CW-1:0] cnt,
                                 input logic [31:0] tgt, input logic with_abort,
                                 output int start_cyc);
        launch_core.delete();
        launch_nonce.delete();
        launch_cyc.delete();
        done_cnt     = 0;
        onehot_err   = 0;
        max_hit_step = 0;
        nonce_base   = base;
        nonce_count  = cnt;
        target       = tgt;
        start        = 1'b1;
        abort        = with_abort;
        start_cyc    = cyc;
        stepCycle();
        start        = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            stepCycle();
            n++;
        end
        repeat (3) stepCycle();
        checkOutput({tag, "_done_count"}, done_cnt, 1);
        checkOutput({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic waitLaunches(input int want);
        int n = 0;
        while (launch_core.size() < want && n < 50) begin
            stepCycle();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        nonce_base = '0; nonce_count = '0; target = '0;
        stepCycle();
        stepCycle();
        checkOutput("rst_ctrl", {busy, done, best_valid, core_start}, 0);
        checkOutput("rst_best", {best_nonce, best_h0}, 0);
        checkOutput("rst_hits_nonce", {hit_count, core_nonce}, 0);
        reset = 1'b0;
        stepCycle();

        // Sweep of 8 over 4 cores; every h0 sits below the target.
        $display("[TB] sweep base 0x100 count 8");
        applyStimulus(32'h100, 8, 32'hFFFF0100, 1'b0, s);
        waitDone("t1");
        checkOutput("t1_launches", launch_core.size(), 8);
        for (int k = 0; k < launch_core.size() && k < 8; k++) begin
            checkOutput($sformatf("t1_core_%0d", k), launch_core[k], k % 4);
            checkOutput($sformatf("t1_nonce_%0d", k), launch_nonce[k], 32'h100 + k);
        end
        if (launch_cyc.size() > 0) checkOutput("t1_first_launch", launch_cyc[0] - s, 2);
        checkOutput("t1_done_lat", done_cyc - last_core_done_cyc, 2);
        checkOutput("t1_onehot", onehot_err, 0);
        checkOutput("t1_hits", hit_count, 8);
        checkOutput("t1_best_nonce", best_nonce, 32'h107);
        checkOutput("t1_best_h0", best_h0, 32'hFFFEFEF9);
        checkOutput("t1_best_valid", best_valid, 1);

        // Base 0: h0 runs FFFF0000 down to FFFEFFF9, all above FFFEFF00.
        $display("[TB] sweep base 0 count 8 target FFFEFF00");
        applyStimulus(32'h0, 8, 32'hFFFEFF00, 1'b0, s);
        waitDone("t2");
        checkOutput("t2_hits", hit_count, 0);
        checkOutput("t2_best_nonce", best_nonce, 32'h7);
        checkOutput("t2_best_h0", best_h0, 32'hFFFEFFF9);
        checkOutput("t2_best_valid", best_valid, 1);

        // Cores 1 and 2 finish together with h0 = 5; core 3 later ties at 5.
        $display("[TB] simultaneous equal results");
        h0_mode = 1;
        lat[1]  = 11;
        applyStimulus(32'h200, 4, 32'h10, 1'b0, s);
        waitDone("t3");
        checkOutput("t3_hits", hit_count, 3);
        checkOutput("t3_hit_step", max_hit_step, 2);
        checkOutput("t3_best_nonce", best_nonce, 32'h201);
        checkOutput("t3_best_h0", best_h0, 32'h5);
        h0_mode = 0;
        lat[1]  = 10;

        // Empty sweep.
        $display("[TB] zero-length sweep");
        applyStimulus(32'h400, 0, 32'hFFFFFFFF, 1'b0, s);
        waitDone("t4");
        checkOutput("t4_launches", launch_core.size(), 0);
        checkOutput("t4_done_lat", done_cyc - s, 2);
        checkOutput("t4_best_valid", best_valid, 0);
        checkOutput("t4_hits", hit_count, 0);

        // Abort once three jobs are out.
        $display("[TB] abort after three launches");
        applyStimulus(32'h300, 8, 32'hFFFFFFFF, 1'b0, s);
        waitLaunches(3);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        waitDone("t5");
        checkOutput("t5_launches", launch_core.size(), 3);
        checkOutput("t5_hits", hit_count, 0);
        checkOutput("t5_best_valid", best_valid, 0);
        checkOutput("t5_done_lat", done_cyc - last_core_done_cyc, 2);

        // Start and abort together in IDLE: the sweep still runs.
        $display("[TB] start with abort in the same cycle");
        applyStimulus(32'h500, 2, 32'hFFFFFFFF, 1'b1, s);
        waitDone("t6");
        checkOutput("t6_launches", launch_core.size(), 2);
        checkOutput("t6_hits", hit_count, 2);
        checkOutput("t6_best_nonce", best_nonce, 32'h501);

        // Nonce wrap, then reset with jobs in flight.
        $display("[TB] wrapping sweep with reset mid-flight");
        applyStimulus(32'hFFFFFFFE, 3, 32'h0, 1'b0, s);
        waitLaunches(3);
        checkOutput("t7_launches", launch_core.size(), 3);
        if (launch_nonce.size() == 3) begin
            checkOutput("t7_nonce_0", launch_nonce[0], 32'hFFFFFFFE);
            checkOutput("t7_nonce_1", launch_nonce[1], 32'hFFFFFFFF);
            checkOutput("t7_nonce_2", launch_nonce[2], 32'h0);
        end
        checkOutput("t7_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("t7_rst_ctrl", {busy, done, best_valid, core_start}, 0);
        checkOutput("t7_rst_vals", {hit_count, core_nonce, best_nonce, best_h0}, 0);
        repeat (3) stepCycle();
        reset = 1'b0;
        repeat (20) stepCycle();
        checkOutput("t7_no_done", done_cnt, 0);
        checkOutput("t7_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
